// File: rtl/set_job_arbiter_if.sv
// Bundle of requester, engine and response signals around set_job_arbiter.
//  req_*  : per-requester job offers and one-hot grant
//  eng_*  : launch pulse, latched job payload, engine status and result
//  rsp_*  : result handshake back toward the requesters
// slave modport is the arbiter's view; master is the surrounding environment.
interface set_job_arbiter_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
);
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [24*N-1:0]   req_central;
  logic [12*N-1:0]   req_radius;
  logic [2*N-1:0]    req_mode;

  logic              eng_en;
  logic [23:0]       eng_central;
  logic [11:0]       eng_radius;
  logic [1:0]        eng_mode;
  logic              eng_busy;
  logic              eng_valid;
  logic [7:0]        eng_candidate;

  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_count;
  logic              rsp_err;
  logic              rsp_ready;

  modport slave (
    input  req_valid, req_central, req_radius, req_mode,
    input  eng_busy, eng_valid, eng_candidate, rsp_ready,
    output req_ready, eng_en, eng_central, eng_radius, eng_mode,
    output rsp_valid, rsp_id, rsp_count, rsp_err
  );

  modport master (
    output req_valid, req_central, req_radius, req_mode,
    output eng_busy, eng_valid, eng_candidate, rsp_ready,
    input  req_ready, eng_en, eng_central, eng_radius, eng_mode,
    input  rsp_valid, rsp_id, rsp_count, rsp_err
  );
endinterface

// File: rtl/set_job_arbiter.sv
// Shares one SET candidate-counting engine between N requesters.
// Round-robin grant, single-cycle launch pulse, completion watchdog, and a
// held response tagged with the requester index.
// Ports:
//  clk  : clock, rising edge
//  rst  : synchronous active-high reset (abandons any job in flight)
//  bus  : set_job_arbiter_if.slave (req_*, eng_*, rsp_* groups)
module set_job_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 128
) (
  input  logic              clk,
  input  logic              rst,
  set_job_arbiter_if.slave  bus
);

  localparam int unsigned WDW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [WDW-1:0]  wd_q;
  logic            eng_en_q;
  logic [23:0]     central_q;
  logic [11:0]     radius_q;
  logic [1:0]      mode_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [7:0]      rsp_count_q;
  logic            rsp_err_q;

  logic            grant_en;
  logic            found;
  logic [IDW-1:0]  cand_idx;
  logic [IDW-1:0]  win_idx;
  logic [N-1:0]    grant_oh;
  logic [1:0]      win_mode;

  // Round-robin scan starting just after the last winner.
  always_comb begin
    found    = 1'b0;
    cand_idx = '0;
    win_idx  = '0;
    for (int k = 1; k <= int'(N); k++) begin
      cand_idx = IDW'((int'(ptr_q) + k) % int'(N));
      if (!found && bus.req_valid[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign grant_en = (state_q == S_IDLE) && !bus.eng_busy && !rst && found;
  assign grant_oh = grant_en ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;
  assign win_mode = bus.req_mode[2*win_idx +: 2];

  assign bus.req_ready   = grant_oh;
  assign bus.eng_en      = eng_en_q;
  assign bus.eng_central = central_q;
  assign bus.eng_radius  = radius_q;
  assign bus.eng_mode    = mode_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_count   = rsp_count_q;
  assign bus.rsp_err     = rsp_err_q;

  // Job FSM; the watchdog counts from the launch cycle so a timeout response
  // lands exactly TIMEOUT cycles after eng_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDW'(N - 1);
      wd_q        <= '0;
      eng_en_q    <= 1'b0;
      central_q   <= '0;
      radius_q    <= '0;
      mode_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_count_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      eng_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_en) begin
            ptr_q     <= win_idx;
            rsp_id_q  <= win_idx;
            central_q <= bus.req_central[24*win_idx +: 24];
            radius_q  <= bus.req_radius[12*win_idx +: 12];
            mode_q    <= win_mode;
            wd_q      <= '0;
            if (win_mode == 2'd3) begin
              rsp_count_q <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              eng_en_q <= 1'b1;
              state_q  <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          wd_q    <= wd_q + 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Result beats timeout when both happen in the same cycle.
          if (bus.eng_valid) begin
            rsp_count_q <= bus.eng_candidate;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (wd_q == WDW'(TIMEOUT - 1)) begin
            rsp_count_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
